// File: rtl/serial_pkg.sv
// Types and helpers for the single-wire bit-serial link, used by the receiver and the
// future transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_t;

  // Even parity over up to 16 data bits. Narrower words are zero-extended by the caller.
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_rx_fsm_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. The reset value is a parameter
// so that the line reads idle-high coming out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clock) begin
    if (reset) ff <= {RST_VAL, RST_VAL};
    else       ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/serial_rx_fsm.sv
// Serial link receiver. Samples at bit centres, deframes start/data/parity/stop, and
// presents each frame with its status through a one-entry valid/ready buffer.
module serial_rx_fsm
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              In,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  rx_state_t         state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              perr, perr_nx;
  logic              in_s;
  logic              done, ferr_now, bit_end, load;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (In),
    .q     (in_s)
  );

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    perr_nx  = perr;
    done     = 1'b0;
    ferr_now = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!in_s) state_nx = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          perr_nx  = 1'b0;
          state_nx = in_s ? IDLE : DATA;
        end else cnt_nx = cnt + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx   = '0;
          // Line is LSB first, so each new bit enters at the top and drifts down.
          shreg_nx = shreg >> 1;
          shreg_nx[DATA_W-1] = in_s;
          if (idx == IDX_LAST) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          else                 idx_nx   = idx + 1'b1;
        end else cnt_nx = cnt + 1'b1;
      end
      PARITY: begin
        if (bit_end) begin
          cnt_nx   = '0;
          perr_nx  = even_parity(16'(shreg)) ^ in_s;
          state_nx = STOP;
        end else cnt_nx = cnt + 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          cnt_nx   = '0;
          done     = 1'b1;
          ferr_now = !in_s;
          state_nx = in_s ? IDLE : WAIT_HI;
        end else cnt_nx = cnt + 1'b1;
      end
      WAIT_HI: begin
        if (in_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      perr  <= perr_nx;
    end
  end

  // A completing frame may take the slot when it is empty or being drained this cycle.
  assign load = done && (!valid || ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done && !load;
      if (load) begin
        valid      <= 1'b1;
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= ferr_now;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
